// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and defaults for the memory access controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  localparam int DEF_DEPTH = 9;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_WAIT = 15;
  localparam int WCW = 4;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter that saturates at zero and flags it
module wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dec,
  input  logic [WCW-1:0] load_val,
  output logic           zero
);
  logic [WCW-1:0] cnt;
  // load on accept, otherwise count down while enabled, holding at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: wait-stated single-port RAM access controller with range check
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DEPTH-1:0] ram_addr,
  output logic             ram_wr_en,
  output logic [WIDTH-1:0] ram_w_data,
  input  logic [WIDTH-1:0] ram_r_data
);
  localparam int WS = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
  localparam logic [WCW-1:0] WLOAD = WCW'((WS > 0) ? WS - 1 : 0);
  state_t state, nxt;
  logic accept, zero, oor_q, we_q;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  assign accept = state == S_IDLE && req;
  assign ram_addr = addr_q;
  assign ram_w_data = wdata_q;
  wait_counter u_wait (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .dec(state == S_WAIT),
    .load_val(WLOAD),
    .zero(zero)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // next state and state-decoded outputs; out-of-range writes never strobe the RAM
  always_comb begin
    nxt = S_IDLE;
    busy = state != S_IDLE;
    done = state == S_DONE;
    err = state == S_DONE && oor_q;
    ram_wr_en = state == S_ACCESS && we_q && !oor_q;
    nxt = state == S_IDLE ? (req ? (WS > 0 ? S_WAIT : S_ACCESS) : S_IDLE) :
          state == S_WAIT ? (zero ? S_ACCESS : S_WAIT) :
          state == S_ACCESS ? S_DONE : S_IDLE;
  end
  // request capture; inputs are ignored until the next accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      oor_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q <= addr[DEPTH-1:0];
      oor_q <= |addr[31:DEPTH];
      we_q <= we;
      wdata_q <= wdata;
    end
  // read result captured at the end of ACCESS; out-of-range reads return zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (state == S_ACCESS && !we_q) rdata <= oor_q ? '0 : ram_r_data;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller sitting directly upstream of the single-port data RAM in the Mini SRC datapath. It accepts read/write requests from the CPU control unit (MAR/MDR side), inserts a programmable number of wait states, and drives the RAM's address, write-data and write-enable pins. It captures the RAM's combinational read data into a registered MDR-facing output and signals completion with a one-cycle pulse. Out-of-range addresses are flagged and never reach memory.

## Interface
- `DEPTH`, 9: RAM address width; 2^DEPTH words.
- `WIDTH`, 32: data word width.
- `WAIT_STATES`, 1: idle cycles inserted before the access cycle (0..15).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  32  byte-independent word address from MAR.
- `wdata`  in  WIDTH  write data from MDR.
- `rdata`  out  WIDTH  registered read result.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  high with `done` when the request was out of range.
- `ram_addr`  out  DEPTH  to RAM `r_addr` and `w_addr`.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_w_data`  out  WIDTH  to RAM `w_data`.
- `ram_r_data`  in  WIDTH  from RAM `r_data` (combinational read).

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: on `req`=1 at a rising edge, latch `addr`, `we`, `wdata` into internal registers; go to WAIT if `WAIT_STATES`>0, else ACCESS. Set `oor` = (`addr[31:DEPTH]` ≠ 0).
- WAIT: down-counter loaded with `WAIT_STATES`-1 on accept; decrement each cycle; go to ACCESS when counter is 0.
- ACCESS: exactly one cycle. `ram_wr_en` = latched `we` & ~`oor` (decoded from state, not registered). Read: at the edge ending ACCESS, `rdata` ← `ram_r_data` if ~`oor`, else 0. Write: `rdata` unchanged. Go to DONE.
- DONE: `done`=1, `err`=`oor`; unconditionally return to IDLE.
- `ram_addr` = latched `addr[DEPTH-1:0]`; `ram_w_data` = latched `wdata`; both stable from the cycle after accept until next accept.
- `req` in WAIT/ACCESS/DONE ignored (not queued); requester must hold or re-issue after `done`.
- Input `addr`/`wdata` changes after accept have no effect.

## Timing
- Accept at edge k: `done` high during the cycle after edge k+`WAIT_STATES`+1; total latency `WAIT_STATES`+2 cycles.
- `busy` high from edge k through the DONE cycle; earliest next accept at the edge ending DONE is not possible (state is DONE then), i.e. next accept at edge k+`WAIT_STATES`+3.
- `ram_wr_en` high exactly one cycle per valid write; RAM commits at the edge ending ACCESS.
- Reset (`rst_n`=0, any time): state IDLE, counter 0, latched regs 0, `rdata`=0, `busy`=`done`=`err`=`ram_wr_en`=0, `ram_addr`=0, `ram_w_data`=0 immediately. A write in ACCESS during reset is aborted (no RAM commit).
- Reset release mid-`req`: first accept at first rising edge with `rst_n`=1 and `req`=1.

## Structure
- Shared package `mem_ctrl_pkg`: state encoding enum (2 bits), default `DEPTH`/`WIDTH`, `WAIT_STATES` max constant.
- One sub-module: `wait_counter` (4-bit loadable down-counter with zero flag, async active-low reset).
- Top-level FSM, latch registers and `rdata` register in `mem_ctrl`.

## Test plan
- `WAIT_STATES`=1, write `addr`=0x005, `wdata`=0xDEADBEEF -> `ram_wr_en` one cycle, `done` 3 cycles after accept, RAM[5]=0xDEADBEEF, `err`=0.
- Read back 0x005 -> `rdata`=0xDEADBEEF at `done`; `ram_wr_en` never high.
- Write `addr`=0x200 (out of range for DEPTH=9) -> `done`=`err`=1, `ram_wr_en` never high, RAM[0] unchanged; read 0x200 -> `rdata`=0.
- `req` held high continuously, `WAIT_STATES`=0 -> accepts every 3 cycles, `done` 2 cycles after each accept, second-request `addr` change mid-access ignored.
- Assert `rst_n`=0 during ACCESS of a write to 0x010 -> `ram_wr_en` drops immediately, RAM[0x10] unchanged, all outputs 0.
- `WAIT_STATES`=15 read -> `busy` high 17 cycles, `done` at cycle 17 after accept.
